// File: rtl/spectrum_pkg.sv
// Shared constants and types for the dual-channel spectrum frame buffer.
package spectrum_pkg;

    localparam int unsigned FFT_POINTS    = 1024;
    localparam int unsigned ADDR_WIDTH    = $clog2(FFT_POINTS);
    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned OVR_CNT_WIDTH = 8;

    localparam logic [ADDR_WIDTH-1:0]    FIRST_BIN   = '0;
    localparam logic [ADDR_WIDTH-1:0]    LAST_BIN    = ADDR_WIDTH'(FFT_POINTS - 1);
    localparam logic [OVR_CNT_WIDTH-1:0] OVR_CNT_MAX = '1;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_e;

    function automatic logic [OVR_CNT_WIDTH-1:0] sat_inc(input logic [OVR_CNT_WIDTH-1:0] v);
        return (v == OVR_CNT_MAX) ? v : v + OVR_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/spectrum_pingpong_bank.sv
// One channel: two frame RAMs used ping-pong, a write FSM that tracks frame
// boundaries, the pending-frame flag with overrun counting, and a registered read port.
module spectrum_pingpong_bank
    import spectrum_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic                     wr_valid,
    input  logic                     frame_sync,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     frame_ready,
    output logic [OVR_CNT_WIDTH-1:0] overrun_cnt
);

    wr_state_e                state_q, state_d;
    logic                     ready_q, ready_d;
    logic [OVR_CNT_WIDTH-1:0] ovr_q, ovr_d;
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank;
    logic                     start, last, swap;
    logic                     wr_en, wr_sel;

    logic [DATA_WIDTH-1:0]    mem0 [FFT_POINTS];
    logic [DATA_WIDTH-1:0]    mem1 [FFT_POINTS];
    logic [DATA_WIDTH-1:0]    q0, q1;
    logic                     rd_sel_q;

    // The read bank is always the one not being written.
    assign rd_bank = ~wr_bank_q;
    assign start   = wr_valid && (wr_addr == FIRST_BIN);
    assign last    = wr_valid && (wr_addr == LAST_BIN);
    assign swap    = frame_sync && ready_q && (state_q == W_IDLE);

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        ovr_d     = ovr_q;
        wr_bank_d = wr_bank_q;
        wr_en     = 1'b0;

        if (swap) begin
            wr_bank_d = ~wr_bank_q;
            ready_d   = 1'b0;
        end

        // A new frame starting over an unswapped one discards it; a frame that is
        // swapped out in this same cycle was displayed, so it is not an overrun.
        if (start && ready_q && !swap) begin
            ready_d = 1'b0;
            ovr_d   = sat_inc(ovr_q);
        end

        unique case (state_q)
            W_IDLE: begin
                if (start) begin
                    wr_en   = 1'b1;
                    state_d = W_FILL;
                end
            end
            W_FILL: begin
                if (wr_valid) begin
                    wr_en = 1'b1;
                    if (last) begin
                        state_d = W_IDLE;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // A write that coincides with a swap lands in the bank that becomes writable.
    assign wr_sel = swap ? ~wr_bank_q : wr_bank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= W_IDLE;
            ready_q   <= 1'b0;
            ovr_q     <= '0;
            wr_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !wr_sel) begin
            mem0[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            q0 <= mem0[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_sel) begin
            mem1[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            q1 <= mem1[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_sel_q <= rd_bank;
        end
    end

    assign rd_data     = rd_sel_q ? q1 : q0;
    assign frame_ready = ready_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: rtl/spectrum_frame_buffer.sv
// Dual-channel spectrum capture with ping-pong banks swapped on display frame sync,
// plus a two-cycle pipelined random-access read port for the renderer.
module spectrum_frame_buffer
    import spectrum_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    ch1_spectrum_data,
    input  logic [ADDR_WIDTH-1:0]    ch1_spectrum_addr,
    input  logic                     ch1_spectrum_valid,
    input  logic [DATA_WIDTH-1:0]    ch2_spectrum_data,
    input  logic [ADDR_WIDTH-1:0]    ch2_spectrum_addr,
    input  logic                     ch2_spectrum_valid,
    input  logic                     frame_sync,
    input  logic                     rd_en,
    input  logic                     rd_ch,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     ch1_frame_ready,
    output logic                     ch2_frame_ready,
    output logic [OVR_CNT_WIDTH-1:0] ch1_overrun_cnt,
    output logic [OVR_CNT_WIDTH-1:0] ch2_overrun_cnt
);

    logic [DATA_WIDTH-1:0] ch1_rd_data, ch2_rd_data;
    logic                  rd_en_q;
    logic                  rd_ch_q;

    spectrum_pingpong_bank u_ch1_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (ch1_spectrum_data),
        .wr_addr     (ch1_spectrum_addr),
        .wr_valid    (ch1_spectrum_valid),
        .frame_sync  (frame_sync),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (ch1_rd_data),
        .frame_ready (ch1_frame_ready),
        .overrun_cnt (ch1_overrun_cnt)
    );

    spectrum_pingpong_bank u_ch2_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (ch2_spectrum_data),
        .wr_addr     (ch2_spectrum_addr),
        .wr_valid    (ch2_spectrum_valid),
        .frame_sync  (frame_sync),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (ch2_rd_data),
        .frame_ready (ch2_frame_ready),
        .overrun_cnt (ch2_overrun_cnt)
    );

    // Stage 1 tracks the RAM read; stage 2 muxes the channel into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q  <= 1'b0;
            rd_ch_q  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_en_q  <= rd_en;
            rd_ch_q  <= rd_ch;
            rd_valid <= rd_en_q;
            if (rd_en_q) begin
                rd_data <= rd_ch_q ? ch2_rd_data : ch1_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// Self-checking bench: directed frame scenarios plus randomized traffic against a
// front/back frame-buffer reference model.
module tb_spectrum_frame_buffer;
    import spectrum_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [DATA_WIDTH-1:0]    ch1_data, ch2_data;
    logic [ADDR_WIDTH-1:0]    ch1_addr, ch2_addr;
    logic                     ch1_valid, ch2_valid;
    logic                     frame_sync;
    logic                     rd_en;
    logic                     rd_ch;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_valid;
    logic                     ch1_frame_ready, ch2_frame_ready;
    logic [OVR_CNT_WIDTH-1:0] ch1_overrun_cnt, ch2_overrun_cnt;

    always #5 clk = ~clk;

    spectrum_frame_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .ch1_spectrum_data  (ch1_data),
        .ch1_spectrum_addr  (ch1_addr),
        .ch1_spectrum_valid (ch1_valid),
        .ch2_spectrum_data  (ch2_data),
        .ch2_spectrum_addr  (ch2_addr),
        .ch2_spectrum_valid (ch2_valid),
        .frame_sync         (frame_sync),
        .rd_en              (rd_en),
        .rd_ch              (rd_ch),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .rd_valid           (rd_valid),
        .ch1_frame_ready    (ch1_frame_ready),
        .ch2_frame_ready    (ch2_frame_ready),
        .ch1_overrun_cnt    (ch1_overrun_cnt),
        .ch2_overrun_cnt    (ch2_overrun_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int rd_valid_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: a displayed (front) and a filling (back) frame per channel.
    bit          filling [2];
    bit          ready   [2];
    int          ovr     [2];
    logic [15:0] front   [2][FFT_POINTS];
    logic [15:0] back    [2][FFT_POINTS];
    bit          front_ok[2][FFT_POINTS];
    bit          back_ok [2][FFT_POINTS];
    bit          pend_en, pend_ok, last_ok;
    logic [15:0] pend_d, last_d;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            filling[c] = 0;
            ready[c]   = 0;
            ovr[c]     = 0;
            // Bank contents survive reset but their front/back roles do not.
            for (int a = 0; a < int'(FFT_POINTS); a++) begin
                front_ok[c][a] = 0;
                back_ok[c][a]  = 0;
            end
        end
        pend_en = 0;
        last_d  = '0;
        last_ok = 1;
    endtask

    task automatic model_write(input int c, input bit v, input int a, input logic [15:0] d,
                               input bit sync);
        logic [15:0] t;
        bit          tk;
        if (sync && ready[c] && !filling[c]) begin
            for (int i = 0; i < int'(FFT_POINTS); i++) begin
                t = front[c][i]; front[c][i] = back[c][i]; back[c][i] = t;
                tk = front_ok[c][i]; front_ok[c][i] = back_ok[c][i]; back_ok[c][i] = tk;
            end
            ready[c] = 0;
        end
        if (v) begin
            if (!filling[c]) begin
                if (a == 0) begin
                    if (ready[c]) begin
                        ready[c] = 0;
                        if (ovr[c] < 255) ovr[c]++;
                    end
                    back[c][0]    = d;
                    back_ok[c][0] = 1;
                    filling[c]    = 1;
                end
            end else begin
                back[c][a]    = d;
                back_ok[c][a] = 1;
                if (a == int'(FFT_POINTS) - 1) begin
                    filling[c] = 0;
                    ready[c]   = 1;
                end
            end
        end
    endtask

    // Apply the current inputs for one clock and compare every output afterwards.
    task automatic step();
        bit          exp_en;
        logic [15:0] exp_d;
        bit          exp_ok;
        exp_en = 0;
        exp_d  = '0;
        exp_ok = 0;
        if (rst) begin
            model_reset();
        end else begin
            exp_en  = pend_en;
            exp_d   = pend_d;
            exp_ok  = pend_ok;
            pend_en = rd_en;
            if (rd_en) begin
                pend_d  = front[rd_ch][rd_addr];
                pend_ok = front_ok[rd_ch][rd_addr];
            end
            model_write(0, ch1_valid, int'(ch1_addr), ch1_data, frame_sync);
            model_write(1, ch2_valid, int'(ch2_addr), ch2_data, frame_sync);
            if (exp_en) begin
                last_d  = exp_d;
                last_ok = exp_ok;
            end
        end
        @(posedge clk);
        #1;
        check("ch1_frame_ready", ch1_frame_ready, ready[0]);
        check("ch2_frame_ready", ch2_frame_ready, ready[1]);
        check("ch1_overrun_cnt", ch1_overrun_cnt, ovr[0]);
        check("ch2_overrun_cnt", ch2_overrun_cnt, ovr[1]);
        check("rd_valid", rd_valid, exp_en);
        if (last_ok) check("rd_data", rd_data, last_d);
        if (rd_valid) rd_valid_cnt++;
        rst        = 0;
        ch1_valid  = 0;
        ch2_valid  = 0;
        frame_sync = 0;
        rd_en      = 0;
    endtask

    task automatic frame(input bit c1, input bit c2, input int lo, input int hi,
                         input logic [15:0] d1, input logic [15:0] d2, input int inc);
        for (int a = lo; a <= hi; a++) begin
            ch1_valid = c1;
            ch1_addr  = ADDR_WIDTH'(a);
            ch1_data  = d1 + 16'(a * inc);
            ch2_valid = c2;
            ch2_addr  = ADDR_WIDTH'(a);
            ch2_data  = d2 + 16'(a * inc);
            step();
        end
    endtask

    task automatic sync();
        frame_sync = 1;
        step();
    endtask

    task automatic rd(input bit ch, input int a);
        rd_en   = 1;
        rd_ch   = ch;
        rd_addr = ADDR_WIDTH'(a);
        step();
    endtask

    int cnt[2];

    initial begin
        rst = 1; ch1_valid = 0; ch2_valid = 0; frame_sync = 0; rd_en = 0; rd_ch = 0;
        ch1_addr = '0; ch2_addr = '0; ch1_data = '0; ch2_data = '0; rd_addr = '0;
        rd_valid_cnt = 0;
        step();
        rst = 1;
        step();
        check("reset_rd_data", rd_data, 0);

        // Full CH1 frame with data=addr, swap, read bin 5.
        frame(1, 0, 0, 1023, 16'h0000, 16'h0000, 1);
        check("t1_ready_set", ch1_frame_ready, 1);
        sync();
        check("t1_ready_clr", ch1_frame_ready, 0);
        rd(0, 5);
        step();
        check("t1_rd_valid", rd_valid, 1);
        check("t1_rd_data", rd_data, 16'd5);

        // Interleaved frames on both channels, single swap.
        frame(1, 1, 0, 1023, 16'h1000, 16'h8000, 1);
        check("t4_ready_both", {ch1_frame_ready, ch2_frame_ready}, 2'b11);
        sync();
        check("t4_clr_both", {ch1_frame_ready, ch2_frame_ready}, 2'b00);
        rd(0, 7);
        rd(1, 7);
        check("t4_ch1_data", rd_data, 16'h1007);
        step();
        check("t4_ch2_data", rd_data, 16'h8007);

        // Partial CH2 frame: sync must not swap.
        frame(0, 1, 0, 500, 16'h0000, 16'h4000, 1);
        sync();
        check("t2_no_ready", ch2_frame_ready, 0);
        rd(1, 5);
        step();
        check("t2_old_bank", rd_data, 16'h8005);

        // Overrun: latest frame wins.
        frame(1, 0, 0, 1023, 16'h1111, 16'h0000, 0);
        check("t3_ready", ch1_frame_ready, 1);
        frame(1, 0, 0, 0, 16'h2222, 16'h0000, 0);
        check("t3_ready_clr", ch1_frame_ready, 0);
        check("t3_ovr", ch1_overrun_cnt, 1);
        frame(1, 0, 1, 1023, 16'h2222, 16'h0000, 0);
        sync();
        rd(0, 100);
        step();
        check("t3_latest", rd_data, 16'h2222);

        // Back-to-back reads straddling a swap.
        frame(1, 0, 0, 1023, 16'h3000, 16'h0000, 1);
        rd_valid_cnt = 0;
        frame_sync = 1;
        rd(0, 0);
        rd(0, 1);
        check("t5_old_bank", rd_data, 16'h2222);
        rd(0, 2);
        check("t5_new_bank1", rd_data, 16'h3001);
        rd(0, 3);
        check("t5_new_bank2", rd_data, 16'h3002);
        step();
        check("t5_new_bank3", rd_data, 16'h3003);
        step();
        check("t5_valid_cnt", rd_valid_cnt, 4);

        // Overrun counter saturation on CH2 with two-write frames.
        for (int i = 0; i < 260; i++) begin
            frame(0, 1, 0, 0, 16'h0000, 16'h7000, 0);
            frame(0, 1, 1023, 1023, 16'h0000, 16'h7001, 0);
        end
        check("ovr_saturate", ch2_overrun_cnt, 255);

        // Reset mid-frame, then a normal frame.
        frame(1, 0, 0, 300, 16'h5000, 16'h0000, 1);
        rst = 1;
        step();
        check("t6_outputs", {ch1_frame_ready, ch2_frame_ready, rd_valid}, 3'b000);
        check("t6_ovr", {ch1_overrun_cnt, ch2_overrun_cnt}, 16'h0000);
        frame(1, 0, 0, 1023, 16'h6000, 16'h0000, 1);
        sync();
        rd(0, 300);
        step();
        check("t6_readback", rd_data, 16'h612c);

        // Randomized traffic with sparse, mostly 16-aligned frames.
        cnt[0] = 0;
        cnt[1] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < 2; c++) begin
                int r;
                int a;
                bit v;
                v = ($urandom % 4) != 0;
                r = int'($urandom % 100);
                if (r < 3) a = 0;
                else if (r < 5) a = int'($urandom % FFT_POINTS);
                else a = cnt[c];
                if (v) begin
                    if (a >= int'(FFT_POINTS) - 1) cnt[c] = 0;
                    else begin
                        cnt[c] = (a / 16) * 16 + 16 * int'($urandom_range(1, 4));
                        if (cnt[c] > int'(FFT_POINTS) - 1) cnt[c] = int'(FFT_POINTS) - 1;
                    end
                end
                if (c == 0) begin
                    ch1_valid = v; ch1_addr = ADDR_WIDTH'(a); ch1_data = 16'($urandom);
                end else begin
                    ch2_valid = v; ch2_addr = ADDR_WIDTH'(a); ch2_data = 16'($urandom);
                end
            end
            frame_sync = ($urandom % 16) == 0;
            rd_en      = ($urandom % 2) != 0;
            rd_ch      = 1'($urandom);
            rd_addr    = (($urandom % 8) == 0) ? ADDR_WIDTH'($urandom)
                                               : ADDR_WIDTH'(16 * ($urandom % 64));
            rst        = ($urandom % 2000) == 0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
